// File: rtl/mdu_seq_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: op codes, FSM states, width.
package mdu_seq_pkg;

    localparam int unsigned W_DEFAULT = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring divide step.
module mdu_step #(
    parameter int unsigned W = 32
) (
    input  logic         i_is_div,
    input  logic [W-1:0] i_hi,
    input  logic [W-1:0] i_lo,
    input  logic [W-1:0] i_m,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    logic [W:0]   w_sum;
    logic [W:0]   w_sh;
    logic [W-1:0] w_diff;
    logic         w_ge;

    always_comb begin
        // Carry bit of the add is shifted into the top of the accumulator.
        w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_m} : {(W + 1){1'b0}});
        w_sh   = {i_hi, i_lo[W-1]};
        w_ge   = (w_sh >= {1'b0, i_m});
        // Only used when w_ge holds, so the difference always fits in W bits.
        w_diff = w_sh[W-1:0] - i_m;
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_sh[W-1:0];
            o_lo = {i_lo[W-2:0], w_ge};
        end else begin
            o_hi = w_sum[W:1];
            o_lo = {w_sum[0], i_lo[W-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative HI/LO multiply/divide sequencer: capture, W iterations, sign fix, done pulse.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div0
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_acc_hi, r_acc_lo, r_m;
    logic          r_is_div, r_neg_q, r_neg_r;
    logic [W-1:0]  r_hi, r_lo;
    logic          r_div0;

    logic          w_accept, w_flush, w_sa, w_sb, w_b0;
    logic [W-1:0]  w_abs_a, w_abs_b, w_step_hi, w_step_lo, w_fix_hi, w_fix_lo;
    logic [2*W-1:0] w_prod;

    assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);
    assign w_flush  = flush && (r_state != S_IDLE);
    assign w_sa     = op_is_signed(op) && a[W-1];
    assign w_sb     = op_is_signed(op) && b[W-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;
    assign w_b0     = op_is_div(op) && (b == '0);

    mdu_step #(
        .W (W)
    ) u_step (
        .i_is_div (r_is_div),
        .i_hi     (r_acc_hi),
        .i_lo     (r_acc_lo),
        .i_m      (r_m),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // The product is negated as a single 2W-bit value; quotient and remainder separately.
    always_comb begin
        w_prod = {r_acc_hi, r_acc_lo};
        if (r_is_div) begin
            w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
            w_fix_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
        end else begin
            if (r_neg_q) begin
                w_prod = -w_prod;
            end
            {w_fix_hi, w_fix_lo} = w_prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div0   <= 1'b0;
        end else if (w_flush) begin
            r_state <= S_IDLE;
        end else if (w_accept) begin
            r_cnt    <= CW'(W - 1);
            r_acc_hi <= '0;
            r_acc_lo <= op_is_div(op) ? w_abs_a : w_abs_b;
            r_m      <= op_is_div(op) ? w_abs_b : w_abs_a;
            r_is_div <= op_is_div(op);
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= w_b0;
            if (w_b0) begin
                r_state <= S_DONE;
                r_hi    <= a;
                r_lo    <= '1;
            end else begin
                r_state <= S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign div0 = r_div0;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic timeline model checked every cycle, plus literal results.
module tb_mdu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, flush;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, div0;
    logic [W-1:0]  hi, lo;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int c0 = 0;

    // Model state: visible results, busy window and done cycle of the op in flight.
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic         m_div0 = 1'b0;
    logic [W-1:0] p_hi, p_lo;
    logic         p_div0;
    logic         m_pend = 1'b0;
    int           m_bs = 1, m_be = 0, m_done_at = -1;

    mdu_seq #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    function automatic void model_result(input logic [1:0] o, input logic [W-1:0] x, y,
                                         output logic [W-1:0] rh, rl, output logic d0);
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        d0 = 1'b0;
        case (o)
            2'b00: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (y == '0) begin
                    d0 = 1'b1; rh = x; rl = '1;
                end else if (o == 2'b10) begin
                    q = sx / sy; r = sx % sy;
                    p = 64'(q); rl = p[31:0];
                    p = 64'(r); rh = p[31:0];
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hi = '0; m_lo = '0; m_div0 = 1'b0;
                m_pend = 1'b0; m_bs = 1; m_be = 0; m_done_at = -1;
            end else begin
                logic bsy, dn;
                bsy = (cyc >= m_bs) && (cyc <= m_be);
                dn  = (cyc == m_done_at);
                if (flush && (bsy || dn)) begin
                    m_pend = 1'b0; m_bs = 1; m_be = 0; m_done_at = -1;
                end else if (start && !flush && !bsy) begin
                    model_result(op, a, b, p_hi, p_lo, p_div0);
                    m_pend = 1'b1;
                    m_div0 = 1'b0;
                    if (p_div0) begin
                        m_bs = 1; m_be = 0; m_done_at = cyc + 1;
                    end else begin
                        m_bs = cyc + 1; m_be = cyc + W + 1; m_done_at = cyc + W + 2;
                    end
                end
                cyc = cyc + 1;
                if (m_pend && cyc == m_done_at) begin
                    m_hi = p_hi; m_lo = p_lo; m_div0 = p_div0; m_pend = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        @(posedge clk);
        forever begin
            logic eb, ed;
            @(negedge clk);
            eb = (cyc >= m_bs) && (cyc <= m_be);
            ed = (cyc == m_done_at);
            tests++;
            if (busy !== eb || done !== ed || hi !== m_hi || lo !== m_lo || div0 !== m_div0) begin
                fails++;
                $display("FAIL cycle%0d: got busy=%b done=%b hi=%h lo=%h div0=%b, expected busy=%b done=%b hi=%h lo=%h div0=%b",
                         cyc, busy, done, hi, lo, div0, eb, ed, m_hi, m_lo, m_div0);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_lat, input logic [W-1:0] eh,
                             input logic [W-1:0] el, input logic ed0);
        int n = 0;
        int nb = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(cyc - c0), 64'(exp_lat));
        chk({nm, "_busy_cycles"}, 64'(nb), (exp_lat == 1) ? 64'd0 : 64'd33);
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        chk({nm, "_div0"}, 64'(div0), 64'(ed0));
    endtask

    initial begin
        int nd;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_div0", 64'(div0), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(2'b11, 32'd100, 32'd7);
        wait_done("divu_b2b", 34, 32'd2, 32'd14, 1'b0);
        @(negedge clk);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 34, 32'h0, 32'h8000_0000, 1'b0);
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min", 34, 32'h4000_0000, 32'h0, 1'b0);
        @(negedge clk);

        issue(2'b11, 32'h0000_1234, 32'd0);
        wait_done("divu_zero", 1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        issue(2'b00, 32'd2, 32'd3);
        chk("div0_clear", 64'(div0), 64'd0);
        wait_done("mult_small", 34, 32'h0, 32'd6, 1'b0);
        @(negedge clk);

        // Flush mid-run; a start pulsed while busy must not be picked up.
        issue(2'b00, 32'd7, 32'd9);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        nd = 0;
        repeat (40) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(nd), 64'd0);
        chk("flush_hilo", {hi, lo}, {32'h0, 32'd6});

        // Flush in idle drops a concurrent start.
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", 64'(busy), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        issue(2'b01, 32'h1234_5678, 32'd9);
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_done_div0", {62'd0, done, div0}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(2'b11, 32'd9, 32'd3);
        wait_done("divu_after_rst", 34, 32'h0, 32'd3, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
